// File: rtl/dna_match_pkg.sv
// Shared defaults and FSM encoding for the DNA match scan controller.
package dna_match_pkg;

    localparam int DEF_WIDTH   = 64;
    localparam int DEF_IDX_W   = 16;
    localparam int DEF_CMP_LAT = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/match_tag_pipe.sv
// Delay line carrying a valid flag and word index alongside the external
// comparator, so each result is paired with the word that produced it.
module match_tag_pipe
    import dna_match_pkg::*;
#(
    parameter int CMP_LAT = DEF_CMP_LAT,
    parameter int IDX_W   = DEF_IDX_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_valid,
    input  logic [IDX_W-1:0] i_idx,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_pending
);

    generate
        if (CMP_LAT == 0) begin : g_bypass
            assign o_valid   = i_valid;
            assign o_idx     = i_idx;
            assign o_pending = 1'b0;
        end else begin : g_pipe
            logic [CMP_LAT-1:0] r_valid;
            logic [IDX_W-1:0]   r_idx [CMP_LAT];

            // Shift tags one stage per cycle; reset flushes every stage.
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_valid <= {CMP_LAT{1'b0}};
                    for (int i = 0; i < CMP_LAT; i++) begin
                        r_idx[i] <= {IDX_W{1'b0}};
                    end
                end else begin
                    r_valid[0] <= i_valid;
                    r_idx[0]   <= i_idx;
                    for (int i = 1; i < CMP_LAT; i++) begin
                        r_valid[i] <= r_valid[i-1];
                        r_idx[i]   <= r_idx[i-1];
                    end
                end
            end

            assign o_valid   = r_valid[CMP_LAT-1];
            assign o_idx     = r_idx[CMP_LAT-1];
            assign o_pending = |r_valid;
        end
    endgenerate

endmodule

// File: rtl/match_scan_controller.sv
// Streams DNA words to an external comparator against a loaded key and
// accumulates match count, found flag and first matching index.
module match_scan_controller
    import dna_match_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int IDX_W   = DEF_IDX_W,
    parameter int CMP_LAT = DEF_CMP_LAT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             key_load,
    input  logic [WIDTH-1:0] key_in,
    input  logic             start,
    input  logic [IDX_W-1:0] num_words,
    input  logic             data_valid,
    input  logic [WIDTH-1:0] data_in,
    output logic             data_ready,
    output logic [WIDTH-1:0] cmp_data,
    output logic [WIDTH-1:0] cmp_key,
    input  logic             cmp_match,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] match_count,
    output logic             found,
    output logic [IDX_W-1:0] first_match_idx
);

    localparam logic [IDX_W-1:0] IDX_ZERO  = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] IDX_MAX   = {IDX_W{1'b1}};
    localparam logic [WIDTH-1:0] WORD_ZERO = {WIDTH{1'b0}};

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_key;
    logic [WIDTH-1:0] r_data;
    logic [IDX_W-1:0] r_word_idx;
    logic [IDX_W-1:0] r_last_idx;
    logic             r_tag_valid;
    logic [IDX_W-1:0] r_tag_idx;
    logic [IDX_W-1:0] r_match_count;
    logic             r_found;
    logic [IDX_W-1:0] r_first_idx;
    logic             r_busy;
    logic             r_done;
    logic             r_data_ready;

    logic             w_start_acc;
    logic             w_accept;
    logic             w_last_word;
    logic             w_pipe_valid;
    logic [IDX_W-1:0] w_pipe_idx;
    logic             w_pipe_pending;
    logic             w_hit;

    assign w_start_acc = (r_state == ST_IDLE) && start;
    assign w_accept    = data_valid && r_data_ready;
    assign w_last_word = w_accept && (r_word_idx == r_last_idx);
    assign w_hit       = w_pipe_valid && cmp_match;

    // r_tag_* lines up with cmp_data; the pipe adds the comparator latency.
    match_tag_pipe #(
        .CMP_LAT (CMP_LAT),
        .IDX_W   (IDX_W)
    ) u_tag_pipe (
        .clock     (clock),
        .reset     (reset),
        .i_valid   (r_tag_valid),
        .i_idx     (r_tag_idx),
        .o_valid   (w_pipe_valid),
        .o_idx     (w_pipe_idx),
        .o_pending (w_pipe_pending)
    );

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (num_words == IDX_ZERO) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = ST_SCAN;
                    end
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (w_last_word) begin
                    w_state_next = ST_DRAIN;
                end else begin
                    w_state_next = ST_SCAN;
                end
            end
            ST_DRAIN: begin
                if (!r_tag_valid && !w_pipe_pending) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register plus status flags registered from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_data_ready <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_busy       <= (w_state_next == ST_SCAN) || (w_state_next == ST_DRAIN);
            r_done       <= (w_state_next == ST_DONE);
            r_data_ready <= (w_state_next == ST_SCAN);
        end
    end

    // Key, word capture, index tagging and result accumulation.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_key         <= WORD_ZERO;
            r_data        <= WORD_ZERO;
            r_word_idx    <= IDX_ZERO;
            r_last_idx    <= IDX_ZERO;
            r_tag_valid   <= 1'b0;
            r_tag_idx     <= IDX_ZERO;
            r_match_count <= IDX_ZERO;
            r_found       <= 1'b0;
            r_first_idx   <= IDX_ZERO;
        end else begin
            if ((r_state == ST_IDLE) && key_load) begin
                r_key <= key_in;
            end
            r_tag_valid <= w_accept;
            if (w_accept) begin
                r_data     <= data_in;
                r_tag_idx  <= r_word_idx;
                r_word_idx <= r_word_idx + IDX_ONE;
            end
            // Results only change on a new scan or on a sampled comparator hit.
            if (w_start_acc) begin
                r_word_idx    <= IDX_ZERO;
                r_last_idx    <= num_words - IDX_ONE;
                r_match_count <= IDX_ZERO;
                r_found       <= 1'b0;
                r_first_idx   <= IDX_ZERO;
            end else if (w_hit) begin
                if (r_match_count != IDX_MAX) begin
                    r_match_count <= r_match_count + IDX_ONE;
                end
                if (!r_found) begin
                    r_found     <= 1'b1;
                    r_first_idx <= w_pipe_idx;
                end
            end
        end
    end

    assign data_ready      = r_data_ready;
    assign cmp_data        = r_data;
    assign cmp_key         = r_key;
    assign busy            = r_busy;
    assign done            = r_done;
    assign match_count     = r_match_count;
    assign found           = r_found;
    assign first_match_idx = r_first_idx;

endmodule

// File: tb/tb_match_scan_controller.sv
// Directed bench for match_scan_controller with a one-cycle registered
// equality comparator model attached to cmp_data/cmp_key.
module tb_match_scan_controller;

    localparam logic [63:0] K  = 64'h20C7A176AAFA69E7;
    localparam logic [63:0] K2 = 64'h0123456789ABCDEF;

    logic        clock;
    logic        reset;
    logic        key_load;
    logic [63:0] key_in;
    logic        start;
    logic [15:0] num_words;
    logic        data_valid;
    logic [63:0] data_in;
    logic        data_ready;
    logic [63:0] cmp_data;
    logic [63:0] cmp_key;
    logic        cmp_match;
    logic        busy;
    logic        done;
    logic [15:0] match_count;
    logic        found;
    logic [15:0] first_match_idx;

    logic [63:0] words [8];
    int          n_checks;
    int          n_pass;
    int          pulses;
    int          first_done;

    match_scan_controller dut (
        .clock           (clock),
        .reset           (reset),
        .key_load        (key_load),
        .key_in          (key_in),
        .start           (start),
        .num_words       (num_words),
        .data_valid      (data_valid),
        .data_in         (data_in),
        .data_ready      (data_ready),
        .cmp_data        (cmp_data),
        .cmp_key         (cmp_key),
        .cmp_match       (cmp_match),
        .busy            (busy),
        .done            (done),
        .match_count     (match_count),
        .found           (found),
        .first_match_idx (first_match_idx)
    );

    always #5 clock = ~clock;

    // External comparator, latency one cycle.
    always_ff @(posedge clock) begin
        if (reset) cmp_match <= 1'b0;
        else       cmp_match <= (cmp_data == cmp_key);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Start a scan of words[0..n-1]; optional gaps and ignored key_load/start noise.
    task automatic run_scan(input logic [63:0] key, input logic load_key, input int n,
                            input bit gaps, input bit noise, output int p, output int fd);
        key_load  = load_key;
        key_in    = key;
        start     = 1'b1;
        num_words = 16'(n);
        tick();
        key_load = 1'b0;
        start    = 1'b0;
        check_eq("ready_in_scan", 64'(data_ready), 64'd1);
        check_eq("busy_in_scan", 64'(busy), 64'd1);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                data_valid = 1'b0;
                tick();
            end
            data_valid = 1'b1;
            data_in    = words[i];
            if (noise) begin
                key_load  = 1'b1;
                key_in    = ~key;
                start     = 1'b1;
                num_words = 16'd1;
            end
            tick();
        end
        data_valid = 1'b0;
        key_load   = 1'b0;
        start      = 1'b0;
        p  = 0;
        fd = -1;
        for (int c = 0; c < 12; c++) begin
            if (done) begin
                p++;
                if (fd < 0) fd = c;
            end
            tick();
        end
    endtask

    initial begin
        clock = 1'b0; reset = 1'b1; key_load = 1'b0; key_in = 64'd0;
        start = 1'b0; num_words = 16'd0; data_valid = 1'b0; data_in = 64'd0;
        n_checks = 0; n_pass = 0;
        tick(); tick(); tick();
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_ready", 64'(data_ready), 64'd0);
        check_eq("rst_count", 64'(match_count), 64'd0);
        check_eq("rst_found", 64'(found), 64'd0);
        check_eq("rst_first", 64'(first_match_idx), 64'd0);
        check_eq("rst_key", cmp_key, 64'd0);
        reset = 1'b0;
        tick();

        // Exact match, key loaded together with start.
        words[0] = K; words[1] = K ^ 64'h0001000000000000; words[2] = K;
        run_scan(K, 1'b1, 3, 1'b0, 1'b0, pulses, first_done);
        check_eq("t1_key", cmp_key, K);
        check_eq("t1_count", 64'(match_count), 64'd2);
        check_eq("t1_found", 64'(found), 64'd1);
        check_eq("t1_first", 64'(first_match_idx), 64'd0);
        check_eq("t1_pulses", 64'(pulses), 64'd1);
        tick(); tick();
        check_eq("t1_hold_count", 64'(match_count), 64'd2);
        check_eq("t1_idle_busy", 64'(busy), 64'd0);

        // Zero-length scan clears prior results and finishes immediately.
        start = 1'b1; num_words = 16'd0;
        tick();
        start = 1'b0;
        check_eq("t3_done", 64'(done), 64'd1);
        check_eq("t3_busy", 64'(busy), 64'd0);
        check_eq("t3_ready", 64'(data_ready), 64'd0);
        check_eq("t3_count", 64'(match_count), 64'd0);
        check_eq("t3_found", 64'(found), 64'd0);
        check_eq("t3_first", 64'(first_match_idx), 64'd0);
        tick();
        check_eq("t3_done_off", 64'(done), 64'd0);
        check_eq("t3_busy_off", 64'(busy), 64'd0);

        // No match.
        words[0] = 64'h0; words[1] = 64'hFFFFFFFFFFFFFFFF;
        words[2] = 64'h20C7A176AAFA69E6; words[3] = 64'hA0C7A176AAFA69E7;
        run_scan(K, 1'b0, 4, 1'b0, 1'b0, pulses, first_done);
        check_eq("t2_count", 64'(match_count), 64'd0);
        check_eq("t2_found", 64'(found), 64'd0);
        check_eq("t2_pulses", 64'(pulses), 64'd1);
        check_eq("t2_drained", 64'(first_done >= 2), 64'd1);

        // Gaps on data_valid; only word 3 matches.
        words[0] = K ^ 64'h1; words[1] = K ^ 64'h2; words[2] = K ^ 64'h4;
        words[3] = K; words[4] = K ^ 64'h8;
        run_scan(K, 1'b0, 5, 1'b1, 1'b0, pulses, first_done);
        check_eq("t4_count", 64'(match_count), 64'd1);
        check_eq("t4_found", 64'(found), 64'd1);
        check_eq("t4_first", 64'(first_match_idx), 64'd3);
        check_eq("t4_pulses", 64'(pulses), 64'd1);

        // Reset after 2 of 6 words.
        key_load = 1'b1; key_in = K; start = 1'b1; num_words = 16'd6;
        tick();
        key_load = 1'b0; start = 1'b0;
        data_valid = 1'b1; data_in = K;          tick();
        data_valid = 1'b1; data_in = K ^ 64'h1;  tick();
        data_valid = 1'b0;
        tick(); tick(); tick();
        check_eq("t5_pre_count", 64'(match_count), 64'd1);
        check_eq("t5_pre_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("t5_busy", 64'(busy), 64'd0);
        check_eq("t5_ready", 64'(data_ready), 64'd0);
        check_eq("t5_done", 64'(done), 64'd0);
        check_eq("t5_count", 64'(match_count), 64'd0);
        check_eq("t5_found", 64'(found), 64'd0);
        check_eq("t5_first", 64'(first_match_idx), 64'd0);
        check_eq("t5_key", cmp_key, 64'd0);
        check_eq("t5_data", cmp_data, 64'd0);
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            if (done) pulses++;
            tick();
        end
        check_eq("t5_no_done", 64'(pulses), 64'd0);
        words[0] = 64'h1; words[1] = K2;
        run_scan(K2, 1'b1, 2, 1'b0, 1'b0, pulses, first_done);
        check_eq("t5_new_count", 64'(match_count), 64'd1);
        check_eq("t5_new_first", 64'(first_match_idx), 64'd1);
        check_eq("t5_new_pulses", 64'(pulses), 64'd1);

        // key_load and start while busy are ignored.
        words[0] = K; words[1] = K ^ 64'h1; words[2] = K;
        run_scan(K, 1'b1, 3, 1'b0, 1'b1, pulses, first_done);
        check_eq("t6_key", cmp_key, K);
        check_eq("t6_count", 64'(match_count), 64'd2);
        check_eq("t6_first", 64'(first_match_idx), 64'd0);
        check_eq("t6_pulses", 64'(pulses), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
